// File: rtl/text_term_pkg.sv
// Shared types and constants for the text terminal: FSM states, ASCII codes, default geometry.
package text_term_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } state_e;

  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_TAB   = 8'h09;
  localparam logic [7:0] ASC_FF    = 8'h0C;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_TILDE = 8'h7E;

  localparam int DEF_COLS     = 70;
  localparam int DEF_ROWS     = 30;
  localparam int DEF_CHAR_W   = 9;
  localparam int DEF_CHAR_H   = 16;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_TAB_STOP = 8;

  localparam int COL_W = 7;
  localparam int ROW_W = 5;
  localparam int PIX_W = 10;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASC_SPACE) && (c <= ASC_TILDE);
  endfunction

endpackage

// File: rtl/text_addr_gen.sv
// Combinational cell address (row*COLS+col) and pixel origin generator; also used by the renderer.
module text_addr_gen
  import text_term_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int CHAR_W = DEF_CHAR_W,
  parameter int CHAR_H = DEF_CHAR_H,
  parameter int ADDR_W = DEF_ADDR_W
)(
  input  logic [COL_W-1:0]  col,
  input  logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  px_x,
  output logic [PIX_W-1:0]  px_y
);

  // Constant multipliers fold to shift-add networks.
  assign addr = ADDR_W'(int'(row) * COLS + int'(col));
  assign px_x = PIX_W'(int'(col) * CHAR_W);
  assign px_y = PIX_W'(int'(row) * CHAR_H);

endmodule

// File: rtl/text_cursor_ctrl.sv
// Text-terminal cursor engine: keyboard codes in, VRAM writes and cursor position out.
// Define TAB_EN to enable tab stops every TAB_STOP columns; otherwise 0x09 is ignored.
module text_cursor_ctrl
  import text_term_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int CHAR_W   = DEF_CHAR_W,
  parameter int CHAR_H   = DEF_CHAR_H,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int TAB_STOP = DEF_TAB_STOP
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_ascii,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row,
  output logic [PIX_W-1:0]  cur_x,
  output logic [PIX_W-1:0]  cur_y,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_data,
  output logic              busy_clear
);

`ifdef TAB_EN
  localparam bit TAB_ON = 1'b1;
`else
  localparam bit TAB_ON = 1'b0;
`endif

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_LASTC = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] SCR_LASTC = ADDR_W'(COLS * ROWS - 1);

  state_e            state, st_nxt;
  logic [COL_W-1:0]  col_nxt;
  logic [ROW_W-1:0]  row_nxt, row_inc;
  logic [ADDR_W-1:0] cur_addr, nxt_addr, clr_addr, clr_cnt;
  logic [PIX_W-1:0]  nxt_x, nxt_y;
  logic              acc_we, acc_bs;
  logic [7:0]        acc_data;
  int                tab_col;

  // One generator on the next cursor: feeds pixel origin, backspace target and clear base.
  text_addr_gen #(
    .COLS(COLS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .ADDR_W(ADDR_W)
  ) u_addr (
    .col(col_nxt), .row(row_nxt), .addr(nxt_addr), .px_x(nxt_x), .px_y(nxt_y)
  );

  assign in_ready = (state == IDLE);
  assign row_inc  = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
  assign tab_col  = (int'(cur_col) / TAB_STOP + 1) * TAB_STOP;

  always_comb begin
    st_nxt   = state;
    col_nxt  = cur_col;
    row_nxt  = cur_row;
    acc_we   = 1'b0;
    acc_bs   = 1'b0;
    acc_data = in_ascii;
    case (state)
      IDLE: if (in_valid) begin
        if (is_printable(in_ascii)) begin
          acc_we = 1'b1;
          if (cur_col != COL_LAST) col_nxt = cur_col + 1'b1;
          else begin
            col_nxt = '0;
            row_nxt = row_inc;
            st_nxt  = CLR_ROW;
          end
        end else begin
          case (in_ascii)
            ASC_CR: begin
              col_nxt = '0;
              row_nxt = row_inc;
              st_nxt  = CLR_ROW;
            end
            ASC_BS: begin
              acc_data = ASC_SPACE;
              if (cur_col != '0) begin
                col_nxt = cur_col - 1'b1;
                acc_we  = 1'b1;
                acc_bs  = 1'b1;
              end else if (cur_row != '0) begin
                col_nxt = COL_LAST;
                row_nxt = cur_row - 1'b1;
                acc_we  = 1'b1;
                acc_bs  = 1'b1;
              end
            end
            ASC_FF: begin
              col_nxt = '0;
              row_nxt = '0;
              st_nxt  = CLR_ALL;
            end
            ASC_TAB: if (TAB_ON) begin
              if (tab_col >= COLS) begin
                col_nxt = '0;
                row_nxt = row_inc;
                st_nxt  = CLR_ROW;
              end else begin
                col_nxt = COL_W'(tab_col);
              end
            end
            default: ;
          endcase
        end
      end
      CLR_ROW: if (clr_cnt == ROW_LASTC) st_nxt = IDLE;
      CLR_ALL: if (clr_cnt == SCR_LASTC) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_col    <= '0;
      cur_row    <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      cur_addr   <= '0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_data  <= ASC_SPACE;
      busy_clear <= 1'b0;
      clr_addr   <= '0;
      clr_cnt    <= '0;
    end else begin
      state      <= st_nxt;
      cur_col    <= col_nxt;
      cur_row    <= row_nxt;
      cur_x      <= nxt_x;
      cur_y      <= nxt_y;
      cur_addr   <= nxt_addr;
      busy_clear <= (st_nxt != IDLE);
      if (state == IDLE) begin
        vram_we <= acc_we;
        if (acc_we) begin
          vram_addr <= acc_bs ? nxt_addr : cur_addr;
          vram_data <= acc_data;
        end
        // Clear always starts at the new cursor row base (0 for form feed).
        clr_addr <= nxt_addr;
        clr_cnt  <= '0;
      end else begin
        vram_we   <= 1'b1;
        vram_addr <= clr_addr;
        vram_data <= ASC_SPACE;
        clr_addr  <= clr_addr + 1'b1;
        clr_cnt   <= clr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Scoreboard bench for text_cursor_ctrl: expected VRAM writes queued by stimulus, popped by a monitor.
module tb_text_cursor_ctrl;
  import text_term_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_ascii = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic [9:0]  cur_x, cur_y;
  logic        vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic        busy_clear;

  text_cursor_ctrl dut (
    .clk(clk), .rst(rst), .in_ascii(in_ascii), .in_valid(in_valid), .in_ready(in_ready),
    .cur_col(cur_col), .cur_row(cur_row), .cur_x(cur_x), .cur_y(cur_y),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data), .busy_clear(busy_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  wr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_wr(input int addr, input logic [7:0] data);
    wr_t w;
    w.addr = 12'(addr);
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic push_clear(input int base, input int n);
    for (int i = 0; i < n; i++) push_wr(base + i, ASC_SPACE);
  endtask

  // Monitor: every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && vram_we === 1'b1) begin
      wr_t e;
      wr_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_write: got addr %0d data 0x%0h expected no write", vram_addr, vram_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(vram_addr), 32'(e.addr));
        chk("wr_data", 32'(vram_data), 32'(e.data));
      end
    end
  end

  task automatic send(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got in_ready %b expected 1", in_ready);
    end
    in_ascii = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_clear(input string name, input int exp_cycles);
    int n = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (busy_clear !== 1'b1) break;
      if (n == 0) chk({name, "_ready_low"}, 32'(in_ready), 32'd0);
      n++;
    end
    chk({name, "_cycles"}, 32'(n), 32'(exp_cycles));
  endtask

  task automatic chk_cur(input string name, input int col, input int row);
    chk({name, "_col"}, 32'(cur_col), 32'(col));
    chk({name, "_row"}, 32'(cur_row), 32'(row));
    chk({name, "_x"}, 32'(cur_x), 32'(col * 9));
    chk({name, "_y"}, 32'(cur_y), 32'(row * 16));
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(vram_we), 32'd0);
    chk("rst_data", 32'(vram_data), 32'h20);
    chk("rst_addr", 32'(vram_addr), 32'd0);
    chk("rst_busy", 32'(busy_clear), 32'd0);
    chk_cur("rst", 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // First printable lands at (0,0), cursor moves one cell.
    push_wr(0, 8'h41);
    send(8'h41);
    @(negedge clk);
    chk_cur("after_A", 1, 0);

    push_wr(0, ASC_SPACE);
    send(ASC_BS);
    @(negedge clk);
    chk_cur("bs_col1", 0, 0);

    send(ASC_BS);
    @(negedge clk);
    chk("bs_origin_we", 32'(vram_we), 32'd0);
    chk_cur("bs_origin", 0, 0);

    send(8'h0A);
    @(negedge clk);
    chk("lf_ignored_we", 32'(vram_we), 32'd0);
    chk_cur("lf_ignored", 0, 0);

    // Fill row 0; the wrap clears row 1.
    for (int i = 0; i < 70; i++) begin
      push_wr(i, 8'(8'h21 + i));
      if (i == 69) push_clear(70, 70);
      send(8'(8'h21 + i));
    end
    wait_clear("wrap", 70);
    chk_cur("wrap", 0, 1);

    push_clear(140, 70);
    send(ASC_CR);
    wait_clear("cr1", 70);
    push_clear(210, 70);
    send(ASC_CR);
    wait_clear("cr2", 70);
    chk_cur("at_row3", 0, 3);

    push_wr(209, ASC_SPACE);
    send(ASC_BS);
    @(negedge clk);
    chk_cur("bs_prev_row", 69, 2);

    push_clear(0, 2100);
    send(ASC_FF);
    wait_clear("ff", 2100);
    chk_cur("ff", 0, 0);
    chk("ff_ready", 32'(in_ready), 32'd1);

    // Walk to row 29, then Enter wraps to row 0.
    for (int r = 1; r < 30; r++) begin
      push_clear(r * 70, 70);
      send(ASC_CR);
      wait_clear("cr_walk", 70);
    end
    for (int i = 0; i < 5; i++) begin
      push_wr(29 * 70 + i, 8'(8'h61 + i));
      send(8'(8'h61 + i));
    end
    @(negedge clk);
    chk_cur("at_5_29", 5, 29);
    push_clear(0, 70);
    send(ASC_CR);
    wait_clear("cr_wrap", 70);
    chk_cur("cr_wrap", 0, 0);

    for (int i = 0; i < 3; i++) begin
      push_wr(i, 8'(8'h78 + i));
      send(8'(8'h78 + i));
    end
`ifdef TAB_EN
    send(ASC_TAB);
    @(negedge clk);
    chk("tab_we", 32'(vram_we), 32'd0);
    chk_cur("tab_to8", 8, 0);
    for (int i = 0; i < 58; i++) begin
      push_wr(8 + i, 8'(8'h30 + i));
      send(8'(8'h30 + i));
    end
    @(negedge clk);
    chk_cur("at_col66", 66, 0);
    push_clear(70, 70);
    send(ASC_TAB);
    wait_clear("tab_wrap", 70);
    chk_cur("tab_wrap", 0, 1);
`else
    send(ASC_TAB);
    @(negedge clk);
    chk("tab_ignored_we", 32'(vram_we), 32'd0);
    chk_cur("tab_ignored", 3, 0);
`endif

    // Form feed with a code held during the clear, aborted by reset at write 1000.
    push_clear(0, 2100);
    base = wr_seen;
    send(ASC_FF);
    in_ascii = 8'h5A;
    in_valid = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #1;
      if (wr_seen >= base + 1000) break;
    end
    chk("abort_write_count", 32'(wr_seen - base), 32'd1000);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("abort_we", 32'(vram_we), 32'd0);
    chk("abort_busy", 32'(busy_clear), 32'd0);
    chk("abort_data", 32'(vram_data), 32'h20);
    chk("abort_addr", 32'(vram_addr), 32'd0);
    chk_cur("abort", 0, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_abort_ready", 32'(in_ready), 32'd1);

    push_wr(0, 8'h51);
    send(8'h51);
    @(negedge clk);
    chk_cur("post_abort", 1, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
